alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand and result width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset that is asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning an operation request is present.
REQ-005 SHALL have port in_ready, output, 1, meaning the unit accepts a request this cycle.
REQ-006 SHALL have port Operation, input, 4, the ALU operation code from the ALU controller.
REQ-007 SHALL have port SrcA, input, DATA_WIDTH, the first operand.
REQ-008 SHALL have port SrcB, input, DATA_WIDTH, the second operand or shift amount.
REQ-009 SHALL have port out_valid, output, 1, meaning ALUResult holds a completed result.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-011 SHALL have port ALUResult, output, DATA_WIDTH, the registered result.

Function
REQ-012 SHALL accept a request on a rising edge where in_valid and in_ready are both 1, capturing Operation, SrcA and SrcB.
REQ-013 SHALL decode: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0100 XOR; 0011 SLL; 0101 SRL; 1010 SRA; 1100 signed less-than; 1101 signed greater-or-equal; 1000 equal; 1001 not-equal.
REQ-014 SHALL produce 1 or 0 in bit 0, upper bits zero, for codes 1100, 1101, 1000 and 1001.
REQ-015 SHALL produce zero for any undefined code, with normal completion timing.
REQ-016 SHALL wrap ADD and SUB modulo 2^DATA_WIDTH, with no overflow flag.
REQ-017 SHALL take the shift amount from SrcB[log2(DATA_WIDTH)-1:0] and ignore the upper bits; SRA replicates SrcA's MSB.
REQ-018 SHALL implement states IDLE, SHIFT and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-019 In IDLE, on accepting a non-shift op, SHALL register the result and enter DONE (latency 1 cycle).
REQ-020 In IDLE, on accepting a shift with amount n: for n = 0, SHALL enter DONE with result SrcA; for n > 0, SHALL enter SHIFT with counter = n.
REQ-021 In SHIFT, SHALL shift the working register one bit per cycle and decrement the counter, entering DONE on the cycle the counter goes 1->0 (latency n+1).
REQ-022 In DONE, SHALL hold ALUResult stable until out_ready = 1, then return to IDLE on that edge.
REQ-023 SHALL ignore in_valid outside IDLE, and SHALL NOT accept a request in the same cycle a result is consumed.

Reset
REQ-024 While reset = 1, SHALL force state IDLE, out_valid = 0, ALUResult = 0, counter = 0, and in_ready = 0.
REQ-025 A reset asserted in SHIFT or DONE SHALL abort the operation and discard its result; no out_valid follows.

Configuration
REQ-026 Macro ALU_FAST_SHIFT_EN defined: shifts SHALL use a single-cycle barrel shifter, the SHIFT state SHALL be unused, and every op SHALL have latency 1.
REQ-027 Macro ALU_FAST_SHIFT_EN undefined: shifts SHALL be iterative per REQ-020/021.

Structure
REQ-028 Package alu_pkg SHALL hold the 4-bit operation-code constants/enum (shared with the ALU controller), the state enum and the DATA_WIDTH default.
REQ-029 A combinational sub-module alu_comb SHALL compute all single-cycle operations; sequencing and the shifter SHALL stay in alu_exec_unit.

Verification
REQ-030 ADD 0x7FFFFFFF + 0x00000001 -> out_valid 1 cycle after accept, ALUResult 0x80000000; SUB 0 - 1 -> 0xFFFFFFFF.
REQ-031 SRA with SrcA 0x80000000 and SrcB 0x00000024 (amount 4) -> out_valid 5 cycles after accept (1 with ALU_FAST_SHIFT_EN), result 0xF8000000; in_ready 0 throughout.
REQ-032 SLL with SrcA 0x1 and amount 0 -> DONE after 1 cycle, result 0x1.
REQ-033 Code 1100 with -1 vs 1 -> 0x1; code 1101 with the same operands -> 0x0; code 0111 -> 0x0.
REQ-034 Hold out_ready = 0 for 3 cycles in DONE while changing the inputs -> ALUResult unchanged and no new accept; then out_ready = 1 -> IDLE and in_ready 1 next cycle.
REQ-035 Assert reset mid-SHIFT (amount 20, cycle 5) -> outputs zero immediately; after release: IDLE, out_valid 0, and a new request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit and the ALU controller:
// operation codes, the sequencer state encoding and the default data width.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 32;

  // 4-bit operation codes as produced by the ALU controller
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_NE  = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_SLT = 4'b1100;
  localparam logic [3:0] OP_SGE = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  // True for the three shift codes, which are sequenced by the exec unit
  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational datapath for every single-cycle ALU operation.
// Shift codes (and undefined codes) yield zero here; shifts are produced
// by the sequencer in alu_exec_unit.
module alu_comb
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  // Select the operation result; compares return a single flag in bit 0
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SLT:  y = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) <  $signed(b))};
      OP_SGE:  y = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) >= $signed(b))};
      OP_EQ:   y = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
      OP_NE:   y = {{(DATA_WIDTH-1){1'b0}}, (a != b)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: accepts one request at a time, sequences it through
// IDLE -> (SHIFT) -> DONE and holds the registered result until consumed.
// Build option: ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter;
// otherwise shifts move one bit per cycle in the SHIFT state.
//
// Handshake: a request is taken on a rising edge with in_valid && in_ready;
// in_ready is high only in IDLE (and low during reset). A result is offered
// with out_valid (DONE only) and is taken on a rising edge with
// out_valid && out_ready; ALUResult is stable while out_valid waits.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic [1:0]            dbg_state
);

  localparam int SW = $clog2(DATA_WIDTH);

  alu_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [DATA_WIDTH-1:0] comb_res;
  logic [SW-1:0]         shamt;
  logic                  accept;

  alu_comb #(.DATA_WIDTH(DATA_WIDTH)) u_comb (
    .op (Operation),
    .a  (SrcA),
    .b  (SrcB),
    .y  (comb_res)
  );

  assign shamt     = SrcB[SW-1:0];
  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign ALUResult = res_q;
  assign dbg_state = state_q;

`ifdef ALU_FAST_SHIFT_EN
  logic [DATA_WIDTH-1:0] barrel_res;

  // Full shift of SrcA by the low operand bits in one cycle
  always_comb begin
    barrel_res = '0;
    case (Operation)
      OP_SLL:  barrel_res = SrcA << shamt;
      OP_SRL:  barrel_res = SrcA >> shamt;
      OP_SRA:  barrel_res = $signed(SrcA) >>> shamt;
      default: barrel_res = '0;
    endcase
  end

  // Next state: every accepted operation completes straight into DONE
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          res_d   = is_shift(Operation) ? barrel_res : comb_res;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

`else
  logic [SW-1:0]         cnt_q, cnt_d;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] step_res;

  // One-bit shift of the working register in the direction of the held op
  always_comb begin
    case (op_q)
      OP_SLL:  step_res = {res_q[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  step_res = {1'b0, res_q[DATA_WIDTH-1:1]};
      default: step_res = {res_q[DATA_WIDTH-1], res_q[DATA_WIDTH-1:1]};
    endcase
  end

  // Next state: shifts with a nonzero amount iterate in SHIFT, all else to DONE
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift(Operation)) begin
            res_d   = SrcA;
            op_d    = Operation;
            cnt_d   = shamt;
            state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
          end else begin
            res_d   = comb_res;
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        res_d = step_res;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, result, counter and held-op registers; reset aborts any operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: a reference model pushes expected
// results into a queue at accept time; they are popped when out_valid rises.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   Operation = 4'd0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] ALUResult;
  logic [1:0]   dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  alu_exec_unit #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [4:0] n;
    n = b[4:0];
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0100: return a ^ b;
      4'b0011: return a << n;
      4'b0101: return a >> n;
      4'b1010: return $signed(a) >>> n;
      4'b1100: return ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
      4'b1101: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return (a == b) ? 32'd1 : 32'd0;
      4'b1001: return (a != b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [W-1:0] b);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    if (op == 4'b0011 || op == 4'b0101 || op == 4'b1010) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // driver + scoreboard: issue one op, measure latency, hold in DONE, consume
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input string name);
    int waitc;
    int lat;
    logic [W-1:0] e;
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 50) begin
      tick();
      waitc++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: in_ready=%b required 1", name, in_ready);
    end
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    exp_q.push_back(model(op, a, b));
    tick();
    in_valid = 1'b0;
    Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_busy_ready: in_ready=%b required 0 (cycle %0d)", name, in_ready, lat);
      end
      tick();
      lat++;
    end
    n_checks++;
    if (lat != exp_lat(op, b)) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat(op, b));
    end
    e = exp_q.pop_front();
    n_checks++;
    if (ALUResult !== e) begin
      n_fail++;
      $display("FAIL %s_result: ALUResult=%h required %h", name, ALUResult, e);
    end
    // hold in DONE while new requests are offered; nothing may change
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
      tick();
      n_checks++;
      if (ALUResult !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_hold: result=%h valid=%b ready=%b required %h 1 0",
                 name, ALUResult, out_valid, in_ready, e);
      end
    end
    // consume; in_valid stays high so a same-cycle accept would show
    in_valid = (hold > 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL %s_consume: valid=%b ready=%b state=%0d required 0 1 %0d",
               name, out_valid, in_ready, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || ALUResult !== '0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_hold: ready=%b valid=%b result=%h state=%0d required 0 0 0 0",
               in_ready, out_valid, ALUResult, dbg_state);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_arith();
    run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, "add_wrap");
    run_op(OP_SUB, 32'h0000_0000, 32'h0000_0001, 0, "sub_wrap");
    run_op(OP_ADD, $urandom, $urandom, 0, "add_rand");
  endtask

  task automatic test_logic();
    run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 0, "and");
    run_op(OP_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 0, "or");
    run_op(OP_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 0, "xor");
    run_op(OP_EQ,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, "eq_true");
    run_op(OP_NE,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, "ne_false");
  endtask

  task automatic test_compare();
    run_op(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 0, "slt");
    run_op(OP_SGE, 32'hFFFF_FFFF, 32'h0000_0001, 0, "sge");
    run_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 0, "undef_0111");
  endtask

  task automatic test_shift();
    run_op(OP_SRA, 32'h8000_0000, 32'h0000_0024, 0, "sra4");
    run_op(OP_SLL, 32'h0000_0001, 32'h0000_0000, 0, "sll0");
    run_op(OP_SRL, 32'h8000_0001, 32'hFFFF_FFFF, 0, "srl31");
    run_op(OP_SLL, 32'h0000_0003, 32'h0000_0021, 0, "sll1");
  endtask

  task automatic test_hold();
    run_op(OP_XOR, 32'h1234_5678, 32'h8765_4321, 3, "hold3");
  endtask

  task automatic test_reset_mid_shift();
    bit seen;
    Operation = OP_SLL; SrcA = $urandom | 32'h1; SrcB = 32'd20; in_valid = 1'b1;
    exp_q.push_back(model(Operation, SrcA, SrcB));
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (dbg_state !== ST_SHIFT || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midshift_state: state=%0d valid=%b required %0d 0", dbg_state, out_valid, ST_SHIFT);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (ALUResult !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL midshift_reset: result=%h valid=%b ready=%b state=%0d required 0 0 0 0",
               ALUResult, out_valid, in_ready, dbg_state);
    end
    exp_q.delete();
    tick(); tick();
    reset = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      tick();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen || dbg_state !== ST_IDLE || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midshift_after: stray_valid=%b state=%0d ready=%b required 0 0 1", seen, dbg_state, in_ready);
    end
    run_op(OP_ADD, 32'd100, 32'd23, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      run_op(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 2), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_compare();
    test_shift();
    test_hold();
    test_reset_mid_shift();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
